// File: rtl/sonic_pkg.sv
// Shared types, constants and width helpers for the multi-channel ultrasonic ranger.
package sonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE,
        GAP
    } state_e;

    localparam int CM_NUM = 17;
    localparam int CM_DEN = 1000;

    // Bit width able to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Bit width able to hold the value max_val.
    function automatic int cnt_w(input int max_val);
        return clog2_min1(max_val + 1);
    endfunction

endpackage

// File: rtl/sonic_ranger_if.sv
// Sensor pins plus per-channel result bus of the ranger; master is the ranger side.
interface sonic_ranger_if
    import sonic_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int DIST_W = 10
);
    localparam int CH_W = clog2_min1(N_CH);

    logic                     en;
    logic [N_CH-1:0]          echo;
    logic [N_CH-1:0]          trig;
    logic [N_CH*DIST_W-1:0]   distance;
    logic [N_CH-1:0]          timeout;
    logic                     dist_valid;
    logic [CH_W-1:0]          dist_ch;

    modport master (
        input  en,
        input  echo,
        output trig,
        output distance,
        output timeout,
        output dist_valid,
        output dist_ch
    );

    modport slave (
        output en,
        output echo,
        input  trig,
        input  distance,
        input  timeout,
        input  dist_valid,
        input  dist_ch
    );
endinterface

// File: rtl/sonic_us_tick.sv
// Microsecond clock-enable: one-clk tick each time the prescaler wraps.
module sonic_us_tick
    import sonic_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);
    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = cnt_w(DIV - 1);
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = (pre_q == PMAX) ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
    end

    assign tick_o = (pre_q == PMAX);

endmodule

// File: rtl/sonic_ranger.sv
// Round-robin HC-SR04 scanner: one trigger per slot, echo timed in microseconds,
// converted to saturated centimetres and published per channel.
module sonic_ranger
    import sonic_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int N_CH       = 2,
    parameter int DIST_W     = 10,
    parameter int TRIG_US    = 10,
    parameter int SLOT_US    = 60000,
    parameter int ECHO_TO_US = 30000
) (
    input  logic           clk,
    input  logic           rst,
    sonic_ranger_if.master bus
);
    localparam int CH_W = clog2_min1(N_CH);
    localparam int SW   = cnt_w(SLOT_US);
    localparam int EW   = cnt_w(ECHO_TO_US);
    localparam int MW   = EW + 5;
    localparam int DW   = (MW > 10) ? MW : 10;

    logic tick;

    sonic_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    logic [N_CH-1:0] sync1_q, sync2_q, sync3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= bus.echo;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    state_e          state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [EW-1:0]   echo_q, echo_d;
    logic            to_q, to_d;
    logic            rise, fall;

    assign rise = sync2_q[ch_q] & ~sync3_q[ch_q];
    assign fall = ~sync2_q[ch_q] & sync3_q[ch_q];

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        echo_d  = echo_q;
        to_d    = to_q;
        slot_d  = (tick && state_q != IDLE) ? slot_q + 1'b1 : slot_q;
        case (state_q)
            IDLE: begin
                // Start on a tick so the trigger and slot always begin µs-aligned.
                if (bus.en && tick) begin
                    state_d = TRIG;
                    ch_d    = '0;
                    slot_d  = '0;
                end
            end
            TRIG: begin
                if (tick && slot_q == SW'(TRIG_US - 1)) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (slot_q == SW'(ECHO_TO_US)) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                end else if (rise) begin
                    state_d = MEASURE;
                    echo_d  = '0;
                    to_d    = 1'b0;
                end
            end
            MEASURE: begin
                if (tick) echo_d = echo_q + 1'b1;
                if (slot_q == SW'(ECHO_TO_US)) begin
                    state_d = DONE;
                    to_d    = 1'b1;
                end else if (fall) begin
                    state_d = DONE;
                    to_d    = 1'b0;
                end
            end
            DONE: begin
                state_d = GAP;
            end
            GAP: begin
                if (tick && slot_q == SW'(SLOT_US - 1)) begin
                    if (bus.en) begin
                        state_d = TRIG;
                        ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
                        slot_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            slot_q  <= '0;
            echo_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            slot_q  <= slot_d;
            echo_q  <= echo_d;
            to_q    <= to_d;
        end
    end

    logic [MW-1:0]     prod;
    logic [DW-1:0]     quo;
    logic [DIST_W-1:0] result;

    always_comb begin
        prod = MW'(echo_q) * MW'(CM_NUM);
        quo  = DW'(prod) / DW'(CM_DEN);
        if (to_q || (|(quo >> DIST_W))) result = '1;
        else                            result = DIST_W'(quo);
    end

    logic [N_CH-1:0]   trig_q;
    logic [DIST_W-1:0] dist_q [N_CH];
    logic [N_CH-1:0]   tflag_q;
    logic              valid_q;
    logic [CH_W-1:0]   dist_ch_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q    <= '0;
            tflag_q   <= '0;
            valid_q   <= 1'b0;
            dist_ch_q <= '0;
            for (int i = 0; i < N_CH; i++) dist_q[i] <= '0;
        end else begin
            trig_q  <= (state_q == TRIG) ? (N_CH'(1) << ch_q) : '0;
            valid_q <= (state_q == DONE);
            if (state_q == DONE) begin
                dist_q[ch_q]  <= result;
                tflag_q[ch_q] <= to_q;
                dist_ch_q     <= ch_q;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_out
            assign bus.distance[gi*DIST_W +: DIST_W] = dist_q[gi];
        end
    endgenerate

    assign bus.trig       = trig_q;
    assign bus.timeout    = tflag_q;
    assign bus.dist_valid = valid_q;
    assign bus.dist_ch    = dist_ch_q;

endmodule

// File: tb/tb_sonic_ranger.sv
// Directed bench: a 2-channel 1 MHz-clock instance for scanning, timeout and reset,
// plus an 8-bit 2 MHz-ratio instance for saturation.
module tb_sonic_ranger;

    logic clk;
    logic rst;
    logic rst_s;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   vcnt = 0;
    int   multi = 0;
    bit   sat_done = 0;

    sonic_ranger_if #(.N_CH(2), .DIST_W(10)) bus0 ();
    sonic_ranger_if #(.N_CH(2), .DIST_W(8))  bus1 ();

    sonic_ranger #(
        .CLK_HZ(1_000_000), .N_CH(2), .DIST_W(10),
        .TRIG_US(10), .SLOT_US(6000), .ECHO_TO_US(5950)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    sonic_ranger #(
        .CLK_HZ(2_000_000), .N_CH(2), .DIST_W(8),
        .TRIG_US(10), .SLOT_US(21500), .ECHO_TO_US(21000)
    ) u_sat (
        .clk (clk),
        .rst (rst_s),
        .bus (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus0.dist_valid) vcnt++;
        if ($countones(bus0.trig) > 1) multi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic wait_trig0(input int limit, output int t, output logic [1:0] which);
        logic [1:0] prev;
        prev  = bus0.trig;
        t     = -1;
        which = 2'b00;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus0.trig != 2'b00 && prev == 2'b00) begin
                t     = cyc;
                which = bus0.trig;
                break;
            end
            prev = bus0.trig;
        end
    endtask

    task automatic trig_width0(output int w);
        w = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus0.trig == 2'b00) break;
            w++;
            @(negedge clk);
        end
    endtask

    task automatic wait_valid0(input int limit, output int t);
        t = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus0.dist_valid) begin
                t = cyc;
                break;
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Saturation instance: 20000 us echo at 8-bit distance.
    initial begin
        int w;
        int found;
        rst_s     = 1'b1;
        bus1.en   = 1'b0;
        bus1.echo = 2'b00;
        repeat (4) @(negedge clk);
        rst_s   = 1'b0;
        bus1.en = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (bus1.trig[0]) found = 1;
        end
        check("s_trig_seen", found, 1);
        w = 0;
        for (int i = 0; i < 100 && bus1.trig[0]; i++) begin
            w++;
            @(negedge clk);
        end
        check("s_trig_width", w, 20);
        repeat (20) @(negedge clk);
        bus1.echo[0] = 1'b1;
        repeat (40000) @(negedge clk);
        bus1.echo[0] = 1'b0;
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(negedge clk);
            if (bus1.dist_valid) found = 1;
        end
        check("s_valid_seen", found, 1);
        check("s_dist_ch", bus1.dist_ch, 0);
        check("s_dist0_sat", bus1.distance[7:0], 255);
        check("s_to0", bus1.timeout[0], 0);
        bus1.en  = 1'b0;
        sat_done = 1'b1;
    end

    initial begin
        int tA, tB, tC, tD, tE, tF, tv, t, w, vB, v0;
        logic [1:0] wh;
        rst       = 1'b1;
        bus0.en   = 1'b0;
        bus0.echo = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_trig", bus0.trig, 0);
        check("rst_distance", bus0.distance, 0);
        check("rst_timeout", bus0.timeout, 0);
        check("rst_valid", bus0.dist_valid, 0);
        check("rst_dist_ch", bus0.dist_ch, 0);
        rst     = 1'b0;
        bus0.en = 1'b1;

        // Slot A, ch0: 5800 us echo -> 98 cm.
        wait_trig0(20, tA, wh);
        check("a_trig_ch0", wh, 2'b01);
        trig_width0(w);
        check("a_trig_width", w, 10);
        repeat (10) @(negedge clk);
        bus0.echo[0] = 1'b1;
        repeat (5800) @(negedge clk);
        bus0.echo[0] = 1'b0;
        wait_valid0(50, tv);
        check("a_valid_seen", tv >= 0, 1);
        check("a_dist_ch", bus0.dist_ch, 0);
        check("a_dist0", bus0.distance[9:0], 98);
        check("a_to0", bus0.timeout[0], 0);

        // Slot B, ch1: no echo -> timeout at 5950 us.
        wait_trig0(7000, tB, wh);
        check("b_trig_ch1", wh, 2'b10);
        check("b_spacing", tB - tA, 6000);
        vB = vcnt;
        wait_valid0(6500, tv);
        check("b_to_latency", (tv - tB >= 5949) && (tv - tB <= 5953), 1);
        check("b_dist_ch", bus0.dist_ch, 1);
        check("b_dist1", bus0.distance[19:10], 1023);
        check("b_to1", bus0.timeout[1], 1);
        check("b_dist0_kept", bus0.distance[9:0], 98);

        // Slot C, ch0: both lines echo 1000 us; only ch0 is measured.
        wait_trig0(7000, tC, wh);
        check("c_trig_ch0", wh, 2'b01);
        check("c_spacing", tC - tB, 6000);
        check("b_one_valid", vcnt - vB, 1);
        repeat (20) @(negedge clk);
        bus0.echo = 2'b11;
        repeat (1000) @(negedge clk);
        bus0.echo = 2'b00;
        wait_valid0(50, tv);
        check("c_dist0", bus0.distance[9:0], 17);
        check("c_to0", bus0.timeout[0], 0);
        check("c_dist1_kept", bus0.distance[19:10], 1023);

        // Slot D, ch1: 1000 us; en dropped mid-slot, result still lands.
        wait_trig0(7000, tD, wh);
        check("d_trig_ch1", wh, 2'b10);
        check("d_spacing", tD - tC, 6000);
        repeat (20) @(negedge clk);
        bus0.echo = 2'b11;
        repeat (100) @(negedge clk);
        bus0.en = 1'b0;
        repeat (900) @(negedge clk);
        bus0.echo = 2'b00;
        wait_valid0(50, tv);
        check("d_dist_ch", bus0.dist_ch, 1);
        check("d_dist1", bus0.distance[19:10], 17);
        check("d_to1", bus0.timeout[1], 0);
        wait_trig0(6500, t, wh);
        check("d_idle_no_trig", t >= 0, 0);

        // Slot E, ch0: echo already high through the trigger -> timeout.
        bus0.echo[0] = 1'b1;
        repeat (3) @(negedge clk);
        bus0.en = 1'b1;
        wait_trig0(50, tE, wh);
        check("e_restart_ch0", wh, 2'b01);
        repeat (200) @(negedge clk);
        bus0.echo[0] = 1'b0;
        wait_valid0(6500, tv);
        check("e_dist_ch", bus0.dist_ch, 0);
        check("e_dist0", bus0.distance[9:0], 1023);
        check("e_to0", bus0.timeout[0], 1);
        check("e_dist1_kept", bus0.distance[19:10], 17);

        // Slot F, ch1: reset 2000 us into MEASURE.
        wait_trig0(7000, tF, wh);
        check("f_trig_ch1", wh, 2'b10);
        check("f_spacing", tF - tE, 6000);
        repeat (20) @(negedge clk);
        bus0.echo[1] = 1'b1;
        repeat (2000) @(negedge clk);
        v0 = vcnt;
        #1 rst = 1'b1;
        #1;
        check("f_rst_distance", bus0.distance, 0);
        check("f_rst_trig", bus0.trig, 0);
        check("f_rst_timeout", bus0.timeout, 0);
        repeat (5) @(negedge clk);
        bus0.echo = 2'b00;
        check("f_no_valid", vcnt - v0, 0);
        check("f_rst_dist_ch", bus0.dist_ch, 0);
        rst = 1'b0;
        wait_trig0(50, t, wh);
        check("f_first_ch0", wh, 2'b01);
        #1 rst = 1'b1;
        #1;
        check("g_async_trig", bus0.trig, 0);
        @(negedge clk);
        rst     = 1'b0;
        bus0.en = 1'b0;
        check("trig_onehot", multi, 0);

        for (int i = 0; i < 60000 && !sat_done; i++) @(negedge clk);
        check("sat_finished", sat_done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sonic_ranger.md
# sonic_ranger

Multi-channel ultrasonic range finder for HC-SR04-class sensors, the parametrised successor to the single-sensor sonic front end. It scans N_CH sensors round-robin, one trigger per time slot so sensors never crosstalk, and times each echo in microseconds from a single system clock using a clock-enable tick; there are no derived clocks. Each result is converted to centimetres, saturated, and published per channel with a valid strobe and a timeout flag. It sits between the sensor pins and the control logic that consumes distances.

## Interface
- CLK_HZ, 100_000_000: system clock frequency; must be a multiple of 1_000_000.
- N_CH, 2: number of sensors, ≥1.
- DIST_W, 10: width of each distance result in cm.
- TRIG_US, 10: trigger pulse length in µs.
- SLOT_US, 60000: period between successive trigger starts in µs.
- ECHO_TO_US, 30000: echo timeout in µs, measured from trigger start; must be < SLOT_US.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; sampled only at slot boundaries.
- echo  in  N_CH  raw sensor echo lines (asynchronous).
- trig  out  N_CH  trigger lines; at most one high at any time.
- distance  out  N_CH*DIST_W  packed per-channel results, channel c at [c*DIST_W +: DIST_W].
- timeout  out  N_CH  per-channel flag; 1 means the latest result for that channel timed out.
- dist_valid  out  1  one-cycle strobe when a result is written.
- dist_ch  out  $clog2(N_CH) (min 1)  channel of the current/last result.

## Operation
- µs tick: prescaler counts 0..CLK_HZ/1e6−1; tick=1 for one clk when it is at its maximum.
- echo: 2-flop synchroniser per channel, plus a delay flop for edge detection. Only the active channel's edges are used.
- FSM states:
  - IDLE: all trig low. When en=1, go to TRIG with ch=0 and slot counter cleared.
  - TRIG: trig[ch]=1 for TRIG_US ticks, then go to WAIT_RISE.
  - WAIT_RISE: a rising edge clears the echo counter and goes to MEASURE.
  - MEASURE: echo counter increments per tick. A falling edge goes to DONE.
  - Timeout: in WAIT_RISE or MEASURE, if the slot counter reaches ECHO_TO_US, go to DONE with timeout set.
  - DONE (one clk): writes distance[ch] and timeout[ch], asserts dist_valid, then goes to GAP.
  - GAP: wait until the slot counter = SLOT_US−1 at a tick. Then, if en=1, set ch←(ch+1) mod N_CH and go to TRIG; otherwise go to IDLE.
- Slot counter: counts ticks from TRIG entry and clears on every TRIG entry.
- Arithmetic on a normal result:
  - d = echo_cnt*17/1000, truncated.
  - Multiply width is counter width + 5.
  - If d > 2^DIST_W−1, distance = 2^DIST_W−1 and timeout=0.
- On timeout: distance = all ones, timeout=1.
- Echo already high at TRIG exit gives no rising edge, so the slot times out. Edges in TRIG or GAP are ignored.
- en deassert mid-slot: the current slot completes, including its result; the block then goes to IDLE. Re-enable restarts at ch=0.
- Untouched channels keep their last distance and timeout.

## Timing
- Reset values: trig=0, distance=0, timeout=0, dist_valid=0, dist_ch=0, state IDLE, prescaler=0. Asserting rst drops trig asynchronously.
- Trigger: trig[ch] rises the clk after TRIG entry and stays high TRIG_US*CLK_HZ/1e6 clks.
- Echo edge latency: 3 clks from pin to edge detect. Echo count resolution is ±1 µs.
- dist_valid: fires 1 clk after DONE entry. distance, timeout and dist_ch are stable from that clk onward.
- Successive trigger rising edges are exactly SLOT_US µs apart while en=1.
- Reset mid-MEASURE: no dist_valid; outputs return to reset values.

## Structure
- Package sonic_pkg holds:
  - the state enum (IDLE, TRIG, WAIT_RISE, MEASURE, DONE, GAP);
  - the constants CM_NUM=17 and CM_DEN=1000;
  - the width helper functions.
- Sub-module sonic_us_tick contains the prescaler and tick output, parameterised by CLK_HZ.
- Synchronisers and the FSM live in sonic_ranger.

## Test plan
- Ch0 echo high 5800 µs after its trigger → dist_valid with dist_ch=0, distance[0]=98, timeout[0]=0.
- en=1, both channels echoing 1000 µs → trig pulses of 10 µs on ch0, ch1, ch0 spaced 60 000 µs apart; distance[0]=distance[1]=17.
- No echo on ch1 → at 30 000 µs after trigger start, distance[1]=1023, timeout[1]=1, dist_valid pulses once.
- DIST_W=8, echo 20 000 µs → distance=255, timeout=0.
- Echo held high through the trigger → timeout=1, distance all ones.
- rst asserted 2000 µs into MEASURE → trig=0 and distance=0 immediately, no dist_valid. After release with en=1, the first trigger is on ch0.
